fpu_result_queue: RTL and testbench
===================================

# fpu_result_queue

Result buffer directly downstream of the FPU core. Captures every completed result (32-bit value, 5-bit exception flags, 4-bit operation tag) the core produces and holds them in a first-word-fall-through FIFO. Results are popped by the Wishbone read path. Also keeps sticky accumulated exception flags (fflags), a sticky overflow flag, and optionally an interrupt request, so firmware can drain results without racing against multi-cycle divide/sqrt completions.

## Interface
Parameters:
- DEPTH, 4: entries; power of two, ≥ 2.
- IRQ_THRESH, 2: occupancy at or above which irq asserts; 1..DEPTH.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; asynchronous, active-low.
- res_valid  in  1  one-cycle pulse: a result is present on res_data/res_exc/res_tag.
- res_data  in  32  result value.
- res_exc  in  5  exception flags {NV, DZ, OF, UF, NX}.
- res_tag  in  4  operation index 0..10 (fclass..sqrt); 11..15 reserved, stored unchanged.
- pop  in  1  remove head entry.
- clr_flags  in  1  clear fflags and overflow.
- rd_data  out  32  head value; 0 when empty.
- rd_exc  out  5  head flags; 0 when empty.
- rd_tag  out  4  head tag; 0 when empty.
- empty  out  1  no entries.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  occupancy.
- fflags  out  5  sticky OR of all res_exc seen.
- overflow  out  1  sticky: a result was dropped.
- irq  out  1  interrupt request.

## Operation
- Storage: DEPTH × 41-bit array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is kept separately.
- Push: res_valid && (!full || pop). Data is written at wr_ptr, wr_ptr increments.
- Pop: pop && !empty. rd_ptr increments. A pop while empty is ignored with no side effects.
- Simultaneous push and pop:
  - Both happen and count is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the pop is ignored and only the push occurs.
- Drop: res_valid && full && !pop. The entry is discarded, storage is untouched, and overflow sets.
- fflags: on every res_valid, including dropped results, fflags |= res_exc.
- clr_flags: fflags and overflow go to 0. If res_valid coincides, the result is fflags = res_exc, and overflow = 1 when that cycle is itself a drop. New events win over the clear.
- Outputs are first-word-fall-through: rd_* present the array entry at rd_ptr, combinationally, gated to 0 by empty.
- irq state machine, two states:
  - IDLE → PEND when count_next ≥ IRQ_THRESH, or when a push carries res_exc[4] (NV) or res_exc[3] (DZ).
  - PEND → IDLE when count_next == 0.
  - irq = (state == PEND), registered.

## Timing
- Reset: pointers, count, fflags, overflow and irq state all 0. Outputs: empty = 1; full, irq and overflow = 0; rd_*, count and fflags = 0. Array contents are not reset.
- Push latency: an entry pushed in cycle N is visible on rd_* and counted in count/empty/full from cycle N+1.
- Pop latency: the next head appears in cycle N+1.
- fflags and overflow update in cycle N+1. irq asserts/deasserts in cycle N+1 of the triggering event.
- Throughput is one push and one pop per cycle sustained.
- Reset asserted mid-operation empties the queue immediately (asynchronously). Entries are lost and overflow is not set.

## Configuration
- FPU_RESQ_IRQ_EN defined: the irq state machine is present as described.
- FPU_RESQ_IRQ_EN undefined: no state machine flops; irq is tied to 0. IRQ_THRESH is accepted but unused. All other behaviour is identical.

## Test plan
- Reset, then 3 pushes (data 0x3F800000 / 0x40000000 / 0x40400000, exc 0) followed by 3 pops → rd_data returns them in order, count goes 1,2,3 then 2,1,0, empty = 1 at the end, fflags = 0.
- Fill DEPTH = 4, then push 0xDEADBEEF without pop → dropped, overflow = 1, count = 4, head unchanged. Fill to 4 again and push with pop in the same cycle → accepted, count stays 4, tail = new value.
- Push exc 5'b00001 then 5'b00100 → fflags = 5'b00101. Assert clr_flags together with a push of exc 5'b10000 → fflags = 5'b10000 next cycle.
- IRQ_EN build, IRQ_THRESH = 2: one push → irq = 0; second push → irq = 1 the next cycle; pop, pop → irq = 0 after count hits 0. One push with NV → irq = 1 at count 1.
- Pop when empty and push simultaneously → count = 1, no underflow, rd_data = pushed value.
- Drive rst_l low asynchronously mid-clock with 3 entries → empty = 1, count = 0, irq = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_result_queue.sv
// rtl/fpu_result_queue.sv - FWFT result buffer behind the FPU core with sticky flags and overflow
// Define FPU_RESQ_IRQ_EN to build the occupancy/exception interrupt state machine; otherwise irq is 0.
module fpu_result_queue #(
  parameter int DEPTH      = 4,
  parameter int IRQ_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       res_valid,
  input  logic [31:0]                res_data,
  input  logic [4:0]                 res_exc,
  input  logic [3:0]                 res_tag,
  input  logic                       pop,
  input  logic                       clr_flags,
  output logic [31:0]                rd_data,
  output logic [4:0]                 rd_exc,
  output logic [3:0]                 rd_tag,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [4:0]                 fflags,
  output logic                       overflow,
  output logic                       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_param
    $error("fpu_result_queue: illegal DEPTH/IRQ_THRESH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    fflags_q, fflags_d;
  logic          overflow_q, overflow_d;
  logic [40:0]   mem_q [DEPTH];
  logic [40:0]   head;
  logic          push_en, pop_en, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop on a full queue frees the slot the concurrent push lands in.
  always_comb begin
    push_en    = res_valid && (!full || pop);
    pop_en     = pop && !empty;
    drop       = res_valid && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fflags_d   = fflags_q;
    overflow_d = overflow_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_en && !pop_en)      count_d = count_q + CW'(1);
    else if (pop_en && !push_en) count_d = count_q - CW'(1);
    // Events in the clearing cycle survive the clear.
    if (clr_flags) begin
      fflags_d   = res_valid ? res_exc : 5'b0;
      overflow_d = drop;
    end else begin
      fflags_d   = fflags_q | (res_valid ? res_exc : 5'b0);
      overflow_d = overflow_q | drop;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fflags_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fflags_q   <= fflags_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= {res_data, res_exc, res_tag};
  end

  assign head     = mem_q[rd_ptr_q];
  assign rd_data  = empty ? 32'b0 : head[40:9];
  assign rd_exc   = empty ? 5'b0  : head[8:4];
  assign rd_tag   = empty ? 4'b0  : head[3:0];
  assign count    = count_q;
  assign fflags   = fflags_q;
  assign overflow = overflow_q;

`ifdef FPU_RESQ_IRQ_EN
  localparam logic [CW-1:0] THRESH = CW'(IRQ_THRESH);

  typedef enum logic {IRQ_IDLE = 1'b0, IRQ_PEND = 1'b1} irq_state_e;
  irq_state_e state_q, state_d;

  // NV/DZ results interrupt immediately regardless of occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (count_d >= THRESH || (push_en && (res_exc[4] || res_exc[3]))) state_d = IRQ_PEND;
      IRQ_PEND: if (count_d == '0) state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= IRQ_IDLE;
    else        state_q <= state_d;
  end

  assign irq = (state_q == IRQ_PEND);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb/tb_fpu_result_queue.sv - directed self-checking bench for fpu_result_queue (DEPTH 4, IRQ_THRESH 2)
module tb_fpu_result_queue;

`ifdef FPU_RESQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic [4:0]  res_exc = '0;
  logic [3:0]  res_tag = '0;
  logic        pop = 1'b0;
  logic        clr_flags = 1'b0;
  logic [31:0] rd_data;
  logic [4:0]  rd_exc;
  logic [3:0]  rd_tag;
  logic        empty, full, overflow, irq;
  logic [2:0]  count;
  logic [4:0]  fflags;

  int checks = 0;
  int errors = 0;

  fpu_result_queue #(.DEPTH(4), .IRQ_THRESH(2)) dut (
    .clk(clk), .rst_l(rst_l), .res_valid(res_valid), .res_data(res_data),
    .res_exc(res_exc), .res_tag(res_tag), .pop(pop), .clr_flags(clr_flags),
    .rd_data(rd_data), .rd_exc(rd_exc), .rd_tag(rd_tag), .empty(empty),
    .full(full), .count(count), .fflags(fflags), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, return 1 time unit after the edge with pulses cleared.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] e,
                      input logic [3:0] t, input logic p, input logic c);
    res_valid = v; res_data = d; res_exc = e; res_tag = t; pop = p; clr_flags = c;
    @(posedge clk); #1;
    res_valid = 1'b0; pop = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL reset_count got %0d/%b exp 0/0", count, full); end
    checks++; if (rd_data !== 32'h0 || rd_exc !== 5'h0 || rd_tag !== 4'h0) begin errors++; $display("FAIL reset_rd got %h/%h/%h exp 0", rd_data, rd_exc, rd_tag); end
    checks++; if (fflags !== 5'h0 || overflow !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_flags got %h/%b/%b exp 0/0/0", fflags, overflow, irq); end
    @(posedge clk); #1; rst_l = 1'b1;
  endtask

  task automatic test_fifo_order();
    logic [31:0] vals [3];
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i], 5'h0, 4'(i + 1), 1'b0, 1'b0);
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL order_push_count[%0d] got %0d exp %0d", i, count, i + 1); end
    end
    checks++; if (rd_tag !== 4'd1) begin errors++; $display("FAIL order_head_tag got %0d exp 1", rd_tag); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== vals[i]) begin errors++; $display("FAIL order_pop_data[%0d] got %h exp %h", i, rd_data, vals[i]); end
      step(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
      checks++; if (count !== 3'(2 - i)) begin errors++; $display("FAIL order_pop_count[%0d] got %0d exp %0d", i, count, 2 - i); end
    end
    checks++; if (empty !== 1'b1 || fflags !== 5'h0 || rd_data !== 32'h0) begin errors++; $display("FAIL order_end got empty=%b fflags=%h rd=%h exp 1/0/0", empty, fflags, rd_data); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 5'h0, 4'h2, 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_full got full=%b count=%0d exp 1/4", full, count); end
    checks++; if (irq !== IRQ_ON) begin errors++; $display("FAIL ovf_irq got %b exp %b", irq, IRQ_ON); end
    step(1'b1, 32'hDEADBEEF, 5'h0, 4'h3, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 3'd4 || rd_data !== 32'hA000_0000) begin errors++; $display("FAIL ovf_drop got ovf=%b count=%0d head=%h exp 1/4/a0000000", overflow, count, rd_data); end
    step(1'b1, 32'hB0B0_B0B0, 5'h0, 4'h4, 1'b1, 1'b0);
    checks++; if (count !== 3'd4 || rd_data !== 32'hA000_0001) begin errors++; $display("FAIL ovf_pushpop got count=%0d head=%h exp 4/a0000001", count, rd_data); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp;
      exp = (i == 3) ? 32'hB0B0_B0B0 : 32'hA000_0001 + 32'(i);
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, rd_data, exp); end
      step(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1 || irq !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_empty got empty=%b irq=%b ovf=%b exp 1/0/1", empty, irq, overflow); end
    step(1'b0, 32'h0, 5'h0, 4'h0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_flags();
    step(1'b1, 32'h1, 5'b00001, 4'h5, 1'b0, 1'b0);
    step(1'b1, 32'h2, 5'b00100, 4'h6, 1'b0, 1'b0);
    checks++; if (fflags !== 5'b00101) begin errors++; $display("FAIL flags_or got %b exp 00101", fflags); end
    checks++; if (rd_exc !== 5'b00001 || rd_tag !== 4'h5) begin errors++; $display("FAIL flags_head got exc=%b tag=%0d exp 00001/5", rd_exc, rd_tag); end
    step(1'b1, 32'h3, 5'b10000, 4'h7, 1'b0, 1'b1);
    checks++; if (fflags !== 5'b10000) begin errors++; $display("FAIL flags_clr_push got %b exp 10000", fflags); end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'h0, 4'h0, 1'b0, 1'b1);
    checks++; if (fflags !== 5'h0 || empty !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL flags_clear got fflags=%b empty=%b irq=%b exp 0/1/0", fflags, empty, irq); end
  endtask

  task automatic test_irq();
    step(1'b1, 32'h11, 5'h0, 4'h1, 1'b0, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_one got %b exp 0", irq); end
    step(1'b1, 32'h22, 5'h0, 4'h1, 1'b0, 1'b0);
    checks++; if (irq !== IRQ_ON) begin errors++; $display("FAIL irq_thresh got %b exp %b", irq, IRQ_ON); end
    step(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
    checks++; if (irq !== IRQ_ON || count !== 3'd1) begin errors++; $display("FAIL irq_hold got irq=%b count=%0d exp %b/1", irq, count, IRQ_ON); end
    step(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
    checks++; if (irq !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL irq_drop got irq=%b count=%0d exp 0/0", irq, count); end
    step(1'b1, 32'h33, 5'b10000, 4'h9, 1'b0, 1'b0);
    checks++; if (irq !== IRQ_ON || count !== 3'd1) begin errors++; $display("FAIL irq_nv got irq=%b count=%0d exp %b/1", irq, count, IRQ_ON); end
    step(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b1);
    checks++; if (irq !== 1'b0 || fflags !== 5'h0) begin errors++; $display("FAIL irq_nv_clear got irq=%b fflags=%b exp 0/0", irq, fflags); end
  endtask

  task automatic test_pop_empty_push();
    step(1'b1, 32'hC0FFEE00, 5'h0, 4'hA, 1'b1, 1'b0);
    checks++; if (count !== 3'd1 || empty !== 1'b0 || rd_data !== 32'hC0FFEE00) begin errors++; $display("FAIL pop_empty got count=%0d empty=%b rd=%h exp 1/0/c0ffee00", count, empty, rd_data); end
    checks++; if (rd_tag !== 4'hA) begin errors++; $display("FAIL pop_empty_tag got %0d exp 10", rd_tag); end
    step(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5000 + 32'(i), 5'h0, 4'h8, 1'b0, 1'b0);
    checks++; if (count !== 3'd3 || irq !== IRQ_ON) begin errors++; $display("FAIL areset_pre got count=%0d irq=%b exp 3/%b", count, irq, IRQ_ON); end
    #2; rst_l = 1'b0; #1;
    checks++; if (empty !== 1'b1 || count !== 3'd0 || irq !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL areset got empty=%b count=%0d irq=%b ovf=%b exp 1/0/0/0", empty, count, irq, overflow); end
    @(posedge clk); #1; rst_l = 1'b1;
    step(1'b0, 32'h0, 5'h0, 4'h0, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1 || rd_data !== 32'h0) begin errors++; $display("FAIL areset_post got empty=%b rd=%h exp 1/0", empty, rd_data); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_flags();
    test_irq();
    test_pop_empty_push();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
